// File: rtl/sensor_request_arbiter.sv
// sensor_request_arbiter
//   Shares one sensor decoder between NUM_REQ command sources with round-robin
//   arbitration. One-shot requests are serialised onto the decoder's
//   enable/request/finished handshake, a minimum idle gap is enforced between
//   decoder reads, and each response is routed back to the requester that issued it.
//
// Optional feature macro: SENSOR_ARB_TIMEOUT_EN
//   Defined: WAIT aborts after TIMEOUT_CYCLES without dec_finished_i and responds 0xEE.
//   Undefined: WAIT exits only on dec_finished_i or reset; no timeout counter exists.
//
// Ports
//   clk_i, rst_i            clock (rising edge), asynchronous active-high reset
//   req_valid_i/req_ready_o per-requester command handshake (ready is a 1-cycle one-hot)
//   req_command_i           8 bits per requester, lane i at [8i+7:8i]
//   req_device_i            32 bits per requester, lane i at [32i+31:32i]
//   rsp_valid_o             1-cycle one-hot response strobe
//   rsp_data_o/rsp_code_o   response payload, valid with rsp_valid_o
//   dec_*                   decoder interface (enable, selector, request, response, finished)
//   busy_o                  high whenever the FSM is not idle
//   grant_id_o              index of the current or last granted requester
module sensor_request_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned MIN_GAP_CYCLES = 100000000,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [8*NUM_REQ-1:0]    req_command_i,
  input  logic [32*NUM_REQ-1:0]   req_device_i,
  output logic [NUM_REQ-1:0]      rsp_valid_o,
  output logic [7:0]              rsp_data_o,
  output logic [7:0]              rsp_code_o,
  output logic                    dec_enable_o,
  output logic [31:0]             dec_device_selector_o,
  output logic [7:0]              dec_request_o,
  input  logic [7:0]              dec_response_i,
  input  logic [7:0]              dec_response_code_i,
  input  logic                    dec_finished_i,
  output logic                    busy_o,
  output logic [2:0]              grant_id_o
);

  typedef enum logic [2:0] {StIdle, StGrant, StGap, StIssue, StWait, StRespond} state_e;

  localparam logic [26:0] GapMax      = 27'(MIN_GAP_CYCLES);
  localparam logic [7:0]  RejectCode  = 8'hEB;
`ifdef SENSOR_ARB_TIMEOUT_EN
  localparam logic [7:0]  TimeoutCode = 8'hEE;
  localparam logic [31:0] ToLast      = 32'(TIMEOUT_CYCLES - 1);
`endif

  state_e               state_q;
  logic [2:0]           rr_q;         // first index searched at the next grant
  logic [2:0]           grant_id_q;
  logic [NUM_REQ-1:0]   req_ready_q;
  logic [7:0]           cmd_q;
  logic [31:0]          dev_q;
  logic                 dec_enable_q;
  logic [31:0]          dec_dev_q;
  logic [7:0]           dec_req_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [7:0]           rsp_data_q;
  logic [7:0]           rsp_code_q;
  logic                 busy_q;
  logic [26:0]          gap_q;
  logic [26:0]          gap_d;
`ifdef SENSOR_ARB_TIMEOUT_EN
  logic [31:0]          to_q;
`endif

  // Zero-padded copies so lanes can be selected with a fixed 3-bit index for any NUM_REQ.
  logic [7:0]           valid_pad;
  logic [63:0]          cmd_pad;
  logic [255:0]         dev_pad;
  logic [3:0]           idx;
  logic [2:0]           win_idx;
  logic                 win_found;
  logic [2:0]           rr_next;
  logic [NUM_REQ-1:0]   win_oh;
  logic [NUM_REQ-1:0]   gid_oh;
  logic                 reject;

  assign valid_pad = 8'(req_valid_i);
  assign cmd_pad   = 64'(req_command_i);
  assign dev_pad   = 256'(req_device_i);

  // Round-robin search starting at rr_q, wrapping modulo NUM_REQ.
  always_comb begin
    idx       = '0;
    win_idx   = rr_q;
    win_found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 4'(rr_q) + 4'(k);
      if (idx >= 4'(NUM_REQ)) idx = idx - 4'(NUM_REQ);
      if (!win_found && valid_pad[idx[2:0]]) begin
        win_found = 1'b1;
        win_idx   = idx[2:0];
      end
    end
  end

  always_comb begin
    rr_next = (win_idx == 3'(NUM_REQ - 1)) ? 3'd0 : win_idx + 3'd1;
    win_oh  = '0;
    gid_oh  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      win_oh[k] = (win_idx == 3'(k));
      gid_oh[k] = (grant_id_q == 3'(k));
    end
  end

  // Monitoring commands would hold the sensor indefinitely; device 0 is not addressable.
  assign reject = ((cmd_q >= 8'h03) && (cmd_q <= 8'h06)) || (dev_q == 32'h0);

  // Gap counter runs everywhere except WAIT and saturates, so an idle arbiter never delays.
  always_comb begin
    gap_d = gap_q;
    if ((state_q != StWait) && (gap_q < GapMax)) gap_d = gap_q + 27'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      rr_q         <= '0;
      grant_id_q   <= '0;
      req_ready_q  <= '0;
      cmd_q        <= '0;
      dev_q        <= '0;
      dec_enable_q <= 1'b0;
      dec_dev_q    <= '0;
      dec_req_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_code_q   <= '0;
      busy_q       <= 1'b0;
      gap_q        <= GapMax;
`ifdef SENSOR_ARB_TIMEOUT_EN
      to_q         <= '0;
`endif
    end else begin
      gap_q <= gap_d;
      case (state_q)
        StIdle: begin
          if (win_found) begin
            state_q     <= StGrant;
            busy_q      <= 1'b1;
            req_ready_q <= win_oh;
            grant_id_q  <= win_idx;
            rr_q        <= rr_next;
            cmd_q       <= cmd_pad[{win_idx, 3'b000} +: 8];
            dev_q       <= dev_pad[{win_idx, 5'b00000} +: 32];
          end
        end
        StGrant: begin
          req_ready_q <= '0;
          if (reject) begin
            state_q     <= StRespond;
            rsp_valid_q <= gid_oh;
            rsp_data_q  <= RejectCode;
            rsp_code_q  <= RejectCode;
          end else begin
            state_q <= StGap;
          end
        end
        StGap: begin
          if (gap_q >= GapMax) state_q <= StIssue;
        end
        StIssue: begin
          dec_enable_q <= 1'b1;
          dec_req_q    <= cmd_q;
          dec_dev_q    <= dev_q;
          state_q      <= StWait;
`ifdef SENSOR_ARB_TIMEOUT_EN
          to_q         <= '0;
`endif
        end
        StWait: begin
          // Enable drops on the finish edge so the decoder cannot retrigger.
          if (dec_finished_i) begin
            dec_enable_q <= 1'b0;
            gap_q        <= '0;
            rsp_valid_q  <= gid_oh;
            rsp_data_q   <= dec_response_i;
            rsp_code_q   <= dec_response_code_i;
            state_q      <= StRespond;
          end
`ifdef SENSOR_ARB_TIMEOUT_EN
          else if (to_q == ToLast) begin
            dec_enable_q <= 1'b0;
            gap_q        <= '0;
            rsp_valid_q  <= gid_oh;
            rsp_data_q   <= TimeoutCode;
            rsp_code_q   <= TimeoutCode;
            state_q      <= StRespond;
          end else begin
            to_q <= to_q + 32'd1;
          end
`endif
        end
        StRespond: begin
          rsp_valid_q <= '0;
          busy_q      <= 1'b0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o           = req_ready_q;
  assign rsp_valid_o           = rsp_valid_q;
  assign rsp_data_o            = rsp_data_q;
  assign rsp_code_o            = rsp_code_q;
  assign dec_enable_o          = dec_enable_q;
  assign dec_device_selector_o = dec_dev_q;
  assign dec_request_o         = dec_req_q;
  assign busy_o                = busy_q;
  assign grant_id_o            = grant_id_q;

endmodule

// File: tb/tb_sensor_request_arbiter.sv
`timescale 1ns/1ps
module tb_sensor_request_arbiter;
  localparam int unsigned NReq    = 4;
  localparam int unsigned MinGap  = 20;
  localparam int unsigned Timeout = 50;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b1;
  logic [3:0]     req_valid_i = '0;
  logic [3:0]     req_ready_o;
  logic [31:0]    req_command_i = '0;
  logic [127:0]   req_device_i = '0;
  logic [3:0]     rsp_valid_o;
  logic [7:0]     rsp_data_o;
  logic [7:0]     rsp_code_o;
  logic           dec_enable_o;
  logic [31:0]    dec_device_selector_o;
  logic [7:0]     dec_request_o;
  logic [7:0]     dec_response_i = '0;
  logic [7:0]     dec_response_code_i = '0;
  logic           dec_finished_i = 1'b0;
  logic           busy_o;
  logic [2:0]     grant_id_o;

  sensor_request_arbiter #(
    .NUM_REQ        (NReq),
    .MIN_GAP_CYCLES (MinGap),
    .TIMEOUT_CYCLES (Timeout)
  ) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .req_valid_i           (req_valid_i),
    .req_ready_o           (req_ready_o),
    .req_command_i         (req_command_i),
    .req_device_i          (req_device_i),
    .rsp_valid_o           (rsp_valid_o),
    .rsp_data_o            (rsp_data_o),
    .rsp_code_o            (rsp_code_o),
    .dec_enable_o          (dec_enable_o),
    .dec_device_selector_o (dec_device_selector_o),
    .dec_request_o         (dec_request_o),
    .dec_response_i        (dec_response_i),
    .dec_response_code_i   (dec_response_code_i),
    .dec_finished_i        (dec_finished_i),
    .busy_o                (busy_o),
    .grant_id_o            (grant_id_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Reference state
  int          next_start = 0;
  logic [7:0]  cmd_tb [4];
  logic [31:0] dev_tb [4];

  // Decoder model state
  bit          dec_hold = 1'b0;
  bit          dec_active = 1'b0;
  int          dec_left = 0;
  int          dec_rises = 0;
  int          last_fin = 0;
  bit          fin_valid = 1'b0;
  int          gap_min = 1000000;
  int          unstable = 0;
  logic [7:0]  seen_req = '0;
  logic [31:0] seen_dev = '0;

  function automatic logic [15:0] dec_reply(input logic [7:0] rq, input logic [31:0] dv);
    logic [7:0] c;
    logic [7:0] d;
    c = rq ^ 8'h12;
    d = (dv[7:0] ^ dv[31:24]) + 8'h18;
    return {c, d};
  endfunction

  function automatic bit is_reject(input logic [7:0] c, input logic [31:0] dv);
    return ((c >= 8'h03) && (c <= 8'h06)) || (dv == 32'h0);
  endfunction

  function automatic int rr_pick(input logic [3:0] pend, input int start);
    for (int k = 0; k < 4; k++) if (pend[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  // Decoder: answers each enable after a random delay with a reply derived from its inputs.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      dec_finished_i = 1'b0;
      if (rst_i) begin
        dec_active = 1'b0;
        fin_valid  = 1'b0;
      end else if (dec_active) begin
        if (dec_enable_o !== 1'b1) begin
          dec_active = 1'b0;
        end else begin
          if (dec_request_o !== seen_req || dec_device_selector_o !== seen_dev) unstable++;
          if (!dec_hold) begin
            dec_left--;
            if (dec_left <= 0) begin
              {dec_response_code_i, dec_response_i} = dec_reply(seen_req, seen_dev);
              dec_finished_i = 1'b1;
              dec_active     = 1'b0;
              last_fin       = cyc + 1;
              fin_valid      = 1'b1;
            end
          end
        end
      end else if (dec_enable_o === 1'b1) begin
        dec_active = 1'b1;
        dec_left   = $urandom_range(1, 6);
        seen_req   = dec_request_o;
        seen_dev   = dec_device_selector_o;
        dec_rises++;
        if (fin_valid && (cyc - last_fin) < gap_min) gap_min = cyc - last_fin;
      end
    end
  end

  task automatic reset_dut();
    req_valid_i = '0;
    dec_hold    = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i      = 1'b0;
    next_start = 0;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    n_cmp++;
    if (req_ready_o !== 4'h0 || rsp_valid_o !== 4'h0) begin
      n_err++;
      $display("FAIL reset_strobes: got ready %b rsp %b want 0000 0000", req_ready_o, rsp_valid_o);
    end
    n_cmp++;
    if (rsp_data_o !== 8'h0 || rsp_code_o !== 8'h0) begin
      n_err++;
      $display("FAIL reset_rsp: got data %h code %h want 00 00", rsp_data_o, rsp_code_o);
    end
    n_cmp++;
    if (dec_enable_o !== 1'b0 || dec_request_o !== 8'h0 || dec_device_selector_o !== 32'h0) begin
      n_err++;
      $display("FAIL reset_dec: got en %b req %h dev %h want 0 00 0", dec_enable_o, dec_request_o,
               dec_device_selector_o);
    end
    n_cmp++;
    if (busy_o !== 1'b0 || grant_id_o !== 3'd0) begin
      n_err++;
      $display("FAIL reset_busy_gid: got %b %0d want 0 0", busy_o, grant_id_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL idle_no_req: got busy %b want 0", busy_o);
    end
  endtask

  task automatic test_latency();
    int ready_at = -1;
    int en_at    = -1;
    int fin_at   = -1;
    int rsp_at   = -1;
    logic [15:0] exp;
    reset_dut();
    req_command_i[7:0] = 8'h01;
    req_device_i[31:0] = 32'h1;
    req_valid_i        = 4'b0001;
    for (int c = 1; c <= 60 && rsp_at < 0; c++) begin
      @(negedge clk_i);
      if (req_ready_o != 4'h0 && ready_at < 0) begin
        ready_at    = c;
        req_valid_i = '0;
        n_cmp++;
        if (req_ready_o !== 4'b0001) begin
          n_err++;
          $display("FAIL lat_ready_vec: got %b want 0001", req_ready_o);
        end
      end
      if (dec_enable_o === 1'b1 && en_at < 0) begin
        en_at = c;
        n_cmp++;
        if (dec_request_o !== 8'h01 || dec_device_selector_o !== 32'h1) begin
          n_err++;
          $display("FAIL lat_dec_inputs: got %h %h want 01 00000001", dec_request_o,
                   dec_device_selector_o);
        end
      end
      if (dec_finished_i === 1'b1) fin_at = c;
      if (rsp_valid_o != 4'h0) begin
        rsp_at = c;
        exp    = dec_reply(8'h01, 32'h1);
        n_cmp++;
        if (rsp_valid_o !== 4'b0001 || rsp_code_o !== 8'h13 || rsp_data_o !== 8'h19
            || exp !== 16'h1319) begin
          n_err++;
          $display("FAIL lat_rsp: got vld %b code %h data %h want 0001 13 19", rsp_valid_o,
                   rsp_code_o, rsp_data_o);
        end
      end
    end
    next_start = 1;
    n_cmp++;
    if (ready_at !== 1) begin
      n_err++;
      $display("FAIL lat_ready_cycle: got %0d want 1", ready_at);
    end
    n_cmp++;
    if (en_at !== 4) begin
      n_err++;
      $display("FAIL lat_enable_cycle: got %0d want 4", en_at);
    end
    n_cmp++;
    if (rsp_at < 0 || rsp_at !== fin_at + 1) begin
      n_err++;
      $display("FAIL lat_rsp_cycle: got %0d want %0d", rsp_at, fin_at + 1);
    end
  endtask

  // Holds each masked requester valid until granted; checks grant order and every response.
  task automatic run_batch(input logic [3:0] mask, input string tag);
    logic [3:0]  pending;
    int          exp_q[$];
    int          exp_rises;
    int          rises0;
    int          unst0;
    int          w;
    logic [7:0]  ec;
    logic [7:0]  ed;
    pending   = mask;
    exp_rises = 0;
    rises0    = dec_rises;
    unst0     = unstable;
    gap_min   = 1000000;
    for (int i = 0; i < 4; i++) begin
      req_command_i[8*i +: 8] = cmd_tb[i];
      req_device_i[32*i +: 32] = dev_tb[i];
    end
    req_valid_i = mask;
    for (int c = 0; c < 800 && (pending != 4'h0 || exp_q.size() != 0); c++) begin
      @(negedge clk_i);
      if (req_ready_o != 4'h0) begin
        w = rr_pick(pending, next_start);
        n_cmp++;
        if (req_ready_o !== 4'(1 << w)) begin
          n_err++;
          $display("FAIL %s grant: got %b want %b", tag, req_ready_o, 4'(1 << w));
        end
        n_cmp++;
        if (grant_id_o !== 3'(w)) begin
          n_err++;
          $display("FAIL %s grant_id: got %0d want %0d", tag, grant_id_o, w);
        end
        pending     = pending & ~req_ready_o;
        req_valid_i = pending;
        next_start  = (w + 1) % 4;
        exp_q.push_back(w);
        if (w >= 0 && !is_reject(cmd_tb[w], dev_tb[w])) exp_rises++;
      end
      if (rsp_valid_o != 4'h0) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL %s unexpected_rsp: got %b want none", tag, rsp_valid_o);
        end else begin
          w = exp_q.pop_front();
          if (w < 0 || is_reject(cmd_tb[w], dev_tb[w])) begin
            ec = 8'hEB;
            ed = 8'hEB;
          end else begin
            {ec, ed} = dec_reply(cmd_tb[w], dev_tb[w]);
          end
          if (rsp_valid_o !== 4'(1 << w) || rsp_code_o !== ec || rsp_data_o !== ed) begin
            n_err++;
            $display("FAIL %s rsp: got vld %b code %h data %h want %b %h %h", tag, rsp_valid_o,
                     rsp_code_o, rsp_data_o, 4'(1 << w), ec, ed);
          end
        end
      end
    end
    req_valid_i = '0;
    n_cmp++;
    if (pending != 4'h0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s completion: got pending %b open %0d want 0000 0", tag, pending,
               exp_q.size());
    end
    n_cmp++;
    if (dec_rises - rises0 != exp_rises) begin
      n_err++;
      $display("FAIL %s dec_rises: got %0d want %0d", tag, dec_rises - rises0, exp_rises);
    end
    n_cmp++;
    if (unstable != unst0) begin
      n_err++;
      $display("FAIL %s dec_stable: got %0d changes want 0", tag, unstable - unst0);
    end
    n_cmp++;
    if (gap_min < int'(MinGap)) begin
      n_err++;
      $display("FAIL %s min_gap: got %0d want >= %0d", tag, gap_min, MinGap);
    end
    @(negedge clk_i);
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s busy_after: got %b want 0", tag, busy_o);
    end
  endtask

  task automatic test_round_robin();
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      cmd_tb[i] = 8'h00;
      dev_tb[i] = 32'h100 + 32'(i);
    end
    run_batch(4'hF, "rr_all");
  endtask

  task automatic test_local_reject();
    for (int i = 0; i < 4; i++) begin
      cmd_tb[i] = 8'h01;
      dev_tb[i] = 32'h2;
    end
    cmd_tb[2] = 8'h03;
    run_batch(4'b0100, "reject_03");
    cmd_tb[0] = 8'h02; dev_tb[0] = 32'h10;
    cmd_tb[1] = 8'h06; dev_tb[1] = 32'h20;
    cmd_tb[2] = 8'h07; dev_tb[2] = 32'h30;
    cmd_tb[3] = 8'h01; dev_tb[3] = 32'h0;
    run_batch(4'hF, "reject_edges");
  endtask

  task automatic test_drop_before_grant();
    int          st = 0;
    bit          saw1 = 1'b0;
    bit          got3 = 1'b0;
    bit          done = 1'b0;
    int          w;
    logic [15:0] exp;
    req_command_i[7:0]    = 8'h00; req_device_i[31:0]   = 32'h9;
    req_command_i[15:8]   = 8'h01; req_device_i[63:32]  = 32'h11;
    req_command_i[31:24]  = 8'h02; req_device_i[127:96] = 32'h33;
    req_valid_i = 4'b0001;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk_i);
      if (req_ready_o[1] === 1'b1) saw1 = 1'b1;
      if (st == 0) begin
        if (req_ready_o != 4'h0) begin
          n_cmp++;
          if (req_ready_o !== 4'b0001) begin
            n_err++;
            $display("FAIL drop_first_grant: got %b want 0001", req_ready_o);
          end
          next_start  = 1;
          req_valid_i = 4'b1010;
          st          = 1;
        end
      end else if (st == 1) begin
        req_valid_i = 4'b1000;
        st          = 2;
      end else begin
        if (req_ready_o != 4'h0) begin
          w = rr_pick(4'b1000, next_start);
          n_cmp++;
          if (req_ready_o !== 4'(1 << w)) begin
            n_err++;
            $display("FAIL drop_second_grant: got %b want %b", req_ready_o, 4'(1 << w));
          end
          next_start  = (w + 1) % 4;
          req_valid_i = '0;
          got3        = 1'b1;
        end
        if (rsp_valid_o != 4'h0) begin
          n_cmp++;
          if (!got3) begin
            exp = dec_reply(8'h00, 32'h9);
            if (rsp_valid_o !== 4'b0001 || {rsp_code_o, rsp_data_o} !== exp) begin
              n_err++;
              $display("FAIL drop_rsp0: got %b %h%h want 0001 %h", rsp_valid_o, rsp_code_o,
                       rsp_data_o, exp);
            end
          end else begin
            exp = dec_reply(8'h02, 32'h33);
            if (rsp_valid_o !== 4'b1000 || {rsp_code_o, rsp_data_o} !== exp) begin
              n_err++;
              $display("FAIL drop_rsp3: got %b %h%h want 1000 %h", rsp_valid_o, rsp_code_o,
                       rsp_data_o, exp);
            end
            done = 1'b1;
          end
        end
      end
    end
    req_valid_i = '0;
    n_cmp++;
    if (!done || saw1) begin
      n_err++;
      $display("FAIL drop_outcome: got done %b ready1 %b want 1 0", done, saw1);
    end
    @(negedge clk_i);
  endtask

  task automatic test_random();
    logic [3:0] m;
    for (int r = 0; r < 8; r++) begin
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        cmd_tb[i] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
        dev_tb[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom);
      end
      run_batch(m, "random");
    end
  endtask

  task automatic test_reset_in_wait();
    bit          in_wait = 1'b0;
    int          high = 0;
    int          bad_rsp = 0;
    int          en_at = -1;
    bit          done = 1'b0;
    logic [15:0] exp;
    dec_hold = 1'b1;
    req_command_i[15:8]  = 8'h01;
    req_device_i[63:32]  = 32'h5;
    req_valid_i = 4'b0010;
    for (int c = 0; c < 150 && !in_wait; c++) begin
      @(negedge clk_i);
      if (req_ready_o != 4'h0) req_valid_i = '0;
      if (dec_enable_o === 1'b1) in_wait = 1'b1;
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (dec_enable_o === 1'b1) high++;
      if (rsp_valid_o != 4'h0) bad_rsp++;
    end
    n_cmp++;
    if (!in_wait || high != 40 || bad_rsp != 0) begin
      n_err++;
      $display("FAIL wait_hold: got wait %b high %0d rsp %0d want 1 40 0", in_wait, high,
               bad_rsp);
    end
    rst_i = 1'b1;
    #1;
    n_cmp++;
    if (dec_enable_o !== 1'b0 || busy_o !== 1'b0 || rsp_valid_o !== 4'h0) begin
      n_err++;
      $display("FAIL async_reset: got en %b busy %b rsp %b want 0 0 0000", dec_enable_o, busy_o,
               rsp_valid_o);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i      = 1'b0;
    next_start = 0;
    dec_hold   = 1'b0;
    req_command_i[31:24] = 8'h02;
    req_device_i[127:96] = 32'h7;
    req_valid_i = 4'b1000;
    for (int c = 1; c <= 80 && !done; c++) begin
      @(negedge clk_i);
      if (req_ready_o != 4'h0) begin
        req_valid_i = '0;
        next_start  = 0;
      end
      if (dec_enable_o === 1'b1 && en_at < 0) en_at = c;
      if (rsp_valid_o != 4'h0) begin
        exp = dec_reply(8'h02, 32'h7);
        n_cmp++;
        if (rsp_valid_o !== 4'b1000 || {rsp_code_o, rsp_data_o} !== exp) begin
          n_err++;
          $display("FAIL post_reset_rsp: got %b %h%h want 1000 %h", rsp_valid_o, rsp_code_o,
                   rsp_data_o, exp);
        end
        done = 1'b1;
      end
    end
    n_cmp++;
    if (en_at !== 4 || !done) begin
      n_err++;
      $display("FAIL post_reset_no_gap: got enable at %0d done %b want 4 1", en_at, done);
    end
    @(negedge clk_i);
  endtask

`ifdef SENSOR_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit seen_en = 1'b0;
    bit done    = 1'b0;
    int high    = 0;
    dec_hold = 1'b1;
    req_command_i[23:16] = 8'h01;
    req_device_i[95:64]  = 32'h3;
    req_valid_i = 4'b0100;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk_i);
      if (req_ready_o != 4'h0) begin
        req_valid_i = '0;
        next_start  = 3;
      end
      if (dec_enable_o === 1'b1) begin
        seen_en = 1'b1;
        high++;
      end else if (seen_en) begin
        n_cmp++;
        if (high != int'(Timeout) || rsp_valid_o !== 4'b0100 || rsp_code_o !== 8'hEE
            || rsp_data_o !== 8'hEE) begin
          n_err++;
          $display("FAIL timeout: got high %0d vld %b code %h data %h want %0d 0100 ee ee",
                   high, rsp_valid_o, rsp_code_o, rsp_data_o, Timeout);
        end
        done = 1'b1;
      end
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL timeout_reached: got %b want 1", done);
    end
    dec_hold = 1'b0;
    @(negedge clk_i);
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: got time %0t want completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_round_robin();
    test_local_reject();
    test_drop_before_grant();
    test_random();
    test_reset_in_wait();
`ifdef SENSOR_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
